// File: rtl/rx_udp_analy.sv
// UDP receive parser: strips the 8-byte UDP header and filters on the port pair.
// It trims link padding by the UDP length field and forwards the payload with sop/eop/mty/err framing.
module rx_udp_analy #(
  parameter int DATA_W = 32,
  parameter int PORT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] cfg_port_local,
  input  logic [PORT_W-1:0] cfg_port_pc,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              din_err,
  input  logic [1:0]        din_mty,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              dout_err,
  output logic [1:0]        dout_mty,
  output logic              flag_port_err,
  output logic              flag_len_err,
  output logic              flag_short_err
);

  typedef enum logic [1:0] {IDLE, HDR1, DATA, DROP} state_t;

  state_t            state_q;
  logic [PORT_W-1:0] src_q, dst_q;
  logic [15:0]       rem_q;
  logic              first_q;
  logic [DATA_W-1:0] dout_q;
  logic              vld_q, sop_q, eop_q, err_q;
  logic [1:0]        mty_q;
  logic              fport_q, flen_q, fshort_q;

  logic [15:0] udp_len_s;
  logic [1:0]  tail_mty_s;
  logic [2:0]  avail_s;
  logic        last_s, short_s, port_ok_s;

  // Length bookkeeping: rem stays in 1..4 on the last word, so 4-rem fits in two bits.
  always_comb begin
    udp_len_s  = din[31:16];
    tail_mty_s = 2'd0 - rem_q[1:0];
    avail_s    = 3'd4 - {1'b0, din_mty};
    last_s     = (rem_q <= 16'd4);
    short_s    = ({13'd0, avail_s} < rem_q);
    port_ok_s  = (src_q == cfg_port_pc) && (dst_q == cfg_port_local);
  end

  // Parser FSM with all outputs registered; outputs default to zero every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= 16'd0;
      first_q  <= 1'b0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      mty_q    <= 2'd0;
      fport_q  <= 1'b0;
      flen_q   <= 1'b0;
      fshort_q <= 1'b0;
    end else begin
      dout_q   <= '0;
      vld_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      mty_q    <= 2'd0;
      fport_q  <= 1'b0;
      flen_q   <= 1'b0;
      fshort_q <= 1'b0;
      if (din_vld) begin
        if (din_sop) begin
          src_q <= din[31:16];
          dst_q <= din[15:0];
          // A datagram interrupted mid-payload is closed with an errored terminator.
          if (state_q == DATA) begin
            vld_q <= 1'b1;
            eop_q <= 1'b1;
            err_q <= 1'b1;
            mty_q <= 2'd3;
          end
          if (din_eop) begin
            fshort_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            state_q  <= HDR1;
          end
        end else begin
          case (state_q)
            IDLE: state_q <= IDLE;
            HDR1: begin
              if (din_eop) begin
                fshort_q <= 1'b1;
                state_q  <= IDLE;
              end else if (!port_ok_s) begin
                fport_q <= 1'b1;
                state_q <= DROP;
              end else if (udp_len_s < 16'd8) begin
                flen_q  <= 1'b1;
                state_q <= DROP;
              end else if (udp_len_s == 16'd8) begin
                state_q <= DROP;
              end else begin
                rem_q   <= udp_len_s - 16'd8;
                first_q <= 1'b1;
                state_q <= DATA;
              end
            end
            DATA: begin
              dout_q  <= din;
              vld_q   <= 1'b1;
              sop_q   <= first_q;
              first_q <= 1'b0;
              if (last_s) begin
                eop_q <= 1'b1;
                mty_q <= tail_mty_s;
                if (din_eop && short_s) begin
                  err_q  <= 1'b1;
                  flen_q <= 1'b1;
                end else begin
                  err_q  <= din_eop & din_err;
                end
                state_q <= din_eop ? IDLE : DROP;
              end else if (din_eop) begin
                eop_q   <= 1'b1;
                mty_q   <= din_mty;
                err_q   <= 1'b1;
                flen_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                rem_q <= rem_q - 16'd4;
              end
            end
            DROP: state_q <= din_eop ? IDLE : DROP;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign dout           = dout_q;
  assign dout_vld       = vld_q;
  assign dout_sop       = sop_q;
  assign dout_eop       = eop_q;
  assign dout_err       = err_q;
  assign dout_mty       = mty_q;
  assign flag_port_err  = fport_q;
  assign flag_len_err   = flen_q;
  assign flag_short_err = fshort_q;

endmodule

// File: tb/tb_rx_udp_analy.sv
// Self-checking bench for rx_udp_analy: directed cases plus random datagrams
// checked against a byte-counting datagram model.
module tb_rx_udp_analy;

  localparam logic [15:0] PC  = 16'h1F90;
  localparam logic [15:0] LOC = 16'h1F91;

  typedef struct packed {
    logic [31:0] d;
    logic        sop, eop, err;
    logic [1:0]  mty;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic        vld, sop, eop, err;
    logic [1:0]  mty;
    logic        fp, fl, fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_port_local, cfg_port_pc;
  logic [31:0] din;
  logic        din_vld, din_sop, din_eop, din_err;
  logic [1:0]  din_mty;
  logic [31:0] dout;
  logic        dout_vld, dout_sop, dout_eop, dout_err;
  logic [1:0]  dout_mty;
  logic        flag_port_err, flag_len_err, flag_short_err;

  beat_t inq[$];
  exp_t  expq[$];
  bit    pend_term;
  int    checks = 0;
  int    passed = 0;
  int    fails  = 0;

  rx_udp_analy dut (
    .clk(clk), .rst(rst),
    .cfg_port_local(cfg_port_local), .cfg_port_pc(cfg_port_pc),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .din_err(din_err), .din_mty(din_mty),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_err(dout_err), .dout_mty(dout_mty),
    .flag_port_err(flag_port_err), .flag_len_err(flag_len_err),
    .flag_short_err(flag_short_err)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e, input string tag);
    exp_t obs;
    obs = '{d: dout, vld: dout_vld, sop: dout_sop, eop: dout_eop, err: dout_err,
            mty: dout_mty, fp: flag_port_err, fl: flag_len_err, fs: flag_short_err};
    checks++;
    assert (obs === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Datagram model: whole packet in, one expected output record per input word.
  task automatic add_pkt(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                         input int n, input bit trunc, input logic [1:0] lmty, input bit lerr);
    bit    hdr_ok;
    int    pl, nw, p;
    beat_t b;
    exp_t  e;
    hdr_ok = (sp == PC) && (dp == LOC) && (len > 16'd8);
    pl = int'(len) - 8;
    nw = hdr_ok ? (pl + 3) / 4 : 0;
    for (int k = 0; k < n; k++) begin
      b.d   = (k == 0) ? {sp, dp} : (k == 1) ? {len, 16'($urandom)} : $urandom;
      b.sop = (k == 0);
      b.eop = !trunc && (k == n - 1);
      b.mty = b.eop ? lmty : 2'd0;
      b.err = b.eop ? lerr : 1'($urandom);
      e = '0;
      if (k == 0) begin
        if (pend_term) begin
          e.vld = 1'b1; e.eop = 1'b1; e.err = 1'b1; e.mty = 2'd3;
        end
        e.fs = b.eop;
      end else if (k == 1) begin
        if (b.eop) e.fs = 1'b1;
        else if (sp != PC || dp != LOC) e.fp = 1'b1;
        else if (len < 16'd8) e.fl = 1'b1;
      end else begin
        p = k - 2;
        if (p < nw) begin
          e.vld = 1'b1; e.d = b.d; e.sop = (p == 0);
          if (p == nw - 1) begin
            e.eop = 1'b1;
            e.mty = 2'(4 * nw - pl);
            if (b.eop && (4 * p + 4 - int'(b.mty)) < pl) begin
              e.err = 1'b1; e.fl = 1'b1;
            end else begin
              e.err = b.eop & b.err;
            end
          end else if (b.eop) begin
            e.eop = 1'b1; e.mty = b.mty; e.err = 1'b1; e.fl = 1'b1;
          end
        end
      end
      inq.push_back(b);
      expq.push_back(e);
    end
    pend_term = trunc && (n >= 2) && hdr_ok && ((n - 2) < nw);
  endtask

  task automatic cycle(input beat_t b, input bit v, input exp_t e, input string tag);
    @(negedge clk);
    din = b.d; din_vld = v; din_sop = b.sop; din_eop = b.eop;
    din_err = b.err; din_mty = b.mty;
    @(posedge clk);
    #1;
    check(e, tag);
  endtask

  // Drain the queued beats, inserting random invalid gap cycles between them.
  task automatic run(input string tag, input bit gaps);
    beat_t b;
    exp_t  e;
    while (inq.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        b = beat_t'({$urandom, 4'($urandom), 2'($urandom)});
        cycle(b, 1'b0, '0, {tag, "_gap"});
      end
      b = inq.pop_front();
      e = expq.pop_front();
      cycle(b, 1'b1, e, tag);
    end
  endtask

  initial begin
    logic [15:0] sp, dp, len;
    int          nwr;
    rst = 1'b1;
    cfg_port_pc = PC; cfg_port_local = LOC;
    din = 32'd0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    din_err = 1'b0; din_mty = 2'd0;
    pend_term = 1'b0;
    repeat (2) @(posedge clk);
    #1 check('0, "reset_state");
    @(negedge clk) rst = 1'b0;

    add_pkt(PC, LOC, 16'h000C, 3, 1'b0, 2'd0, 1'b0);      run("basic", 1'b0);
    add_pkt(PC, LOC, 16'h000A, 5, 1'b0, 2'd0, 1'b0);      run("padded", 1'b0);
    add_pkt(16'h1F92, LOC, 16'h000C, 3, 1'b0, 2'd0, 1'b0); run("port_src", 1'b0);
    add_pkt(PC, 16'h0001, 16'h0010, 4, 1'b0, 2'd0, 1'b0); run("port_dst", 1'b0);
    add_pkt(PC, LOC, 16'h0014, 4, 1'b0, 2'd0, 1'b0);      run("short_payload", 1'b0);
    add_pkt(PC, LOC, 16'h0004, 3, 1'b0, 2'd0, 1'b0);      run("len_lt8", 1'b0);
    add_pkt(PC, LOC, 16'h0008, 3, 1'b0, 2'd0, 1'b0);      run("len_eq8", 1'b0);
    add_pkt(PC, LOC, 16'h0010, 2, 1'b0, 2'd0, 1'b0);      run("eop_hdr1", 1'b0);
    add_pkt(PC, LOC, 16'h000F, 4, 1'b0, 2'd1, 1'b1);      run("mty_err_in", 1'b0);
    add_pkt(PC, LOC, 16'h000F, 4, 1'b0, 2'd2, 1'b0);      run("mty_short", 1'b0);
    add_pkt(PC, LOC, 16'hFFFF, 4, 1'b0, 2'd3, 1'b0);      run("len_huge", 1'b0);

    add_pkt(PC, LOC, 16'h0028, 4, 1'b1, 2'd0, 1'b0);
    add_pkt(PC, LOC, 16'h000C, 3, 1'b0, 2'd0, 1'b0);      run("sop_in_data", 1'b0);
    add_pkt(PC, LOC, 16'h0028, 3, 1'b1, 2'd0, 1'b0);
    add_pkt(PC, LOC, 16'h0028, 1, 1'b0, 2'd0, 1'b0);
    add_pkt(PC, LOC, 16'h0010, 4, 1'b0, 2'd0, 1'b0);      run("sop_eop_term", 1'b0);

    add_pkt(PC, LOC, 16'h0028, 4, 1'b1, 2'd0, 1'b0);      run("pre_rst", 1'b0);
    pend_term = 1'b0;
    @(negedge clk);
    rst = 1'b1; din_vld = 1'b0;
    #1 check('0, "rst_async");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inq.push_back(beat_t'({$urandom, 1'b0, 1'b0, 1'b0, 2'd0}));
      expq.push_back('0);
    end
    run("stray", 1'b0);
    add_pkt(PC, LOC, 16'h0012, 5, 1'b0, 2'd2, 1'b0);      run("post_rst", 1'b0);

    for (int i = 0; i < 80; i++) begin
      sp  = ($urandom_range(0, 7) == 0) ? (PC ^ 16'h0004) : PC;
      dp  = ($urandom_range(0, 7) == 0) ? (LOC ^ 16'h0100) : LOC;
      len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 8))
                                        : 16'($urandom_range(9, 48));
      nwr = (len > 16'd8) ? (int'(len) - 8 + 3) / 4 : 0;
      add_pkt(sp, dp, len, $urandom_range(1, nwr + 4), ($urandom_range(0, 5) == 0),
              2'($urandom), 1'($urandom));
      run("random", 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
